io_unit: RTL and testbench
==========================

IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 Parameter NUM_SW, 18, number of slide switches, 1..18.
REQ-002 Parameter NUM_KEY, 4, number of push keys, 1..4.
REQ-003 Parameter NUM_HEX, 4..8, default 8, number of seven-segment digits.
REQ-004 Parameter DEB_CYCLES, 4, debounce stable-count length, >=2.
REQ-005 Port clock  in  1  sole clock, rising edge.
REQ-006 Port reset_n  in  1  reset, asynchronous, active-low.
REQ-007 Port opcode  in  6  instruction opcode; 6'b011011 = IN, 6'b011100 = OUT.
REQ-008 Port address  in  5  IO target.
REQ-009 Port data  in  32  OUT operand.
REQ-010 Port valid  in  1  instruction request, accepted when valid=1 and ready=1.
REQ-011 Port ready  out  1  1 = idle, can accept a request.
REQ-012 Port sw  in  NUM_SW  raw switches, asynchronous.
REQ-013 Port key  in  NUM_KEY  raw keys, active-low (0 = pressed), asynchronous.
REQ-014 Port in_data  out  32  IN result, zero-extended 1-bit value.
REQ-015 Port in_valid  out  1  one-cycle pulse qualifying in_data.
REQ-016 Port hex  out  7*NUM_HEX  segments, digit i at [7i+6:7i], active-low, bit0 = segment g.
REQ-017 Port lcd_data, lcd_line, lcd_we  out  32/1/1  LCD word, line select, one-cycle write strobe.

Function
REQ-018 sw and key SHALL pass through 2-flop synchronisers before any use.
REQ-019 IN: address < NUM_SW returns sw[address]; NUM_SW..NUM_SW+NUM_KEY-1 returns debounced pressed state of key[address-NUM_SW]; any other address returns 0.
REQ-020 IN: in_data registered, in_valid pulses the cycle after acceptance (latency 1); ready stays 1.
REQ-021 OUT to address < NUM_HEX: digit[address] <= code(data) next cycle; data 0..9 use codes 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,0000000,0001100; data > 9 gives blank 1111111.
REQ-022 OUT to address 8/9: lcd_data <= data, lcd_line <= address[0], lcd_we pulses one cycle, next cycle.
REQ-023 OUT to address 31 (decimal mode): FSM IDLE -> CONVERT (32 cycles double-dabble shift-add-3 into 10 BCD digits) -> WRITE (1 cycle) -> IDLE; ready = 0 in CONVERT and WRITE (33 cycles).
REQ-024 WRITE: digit i <= code(BCD i); leading zeros above highest nonzero digit blanked; digit 0 always shown.
REQ-025 WRITE overflow (any BCD digit >= NUM_HEX nonzero): every digit <= dash 1111110.
REQ-026 valid while ready=0 SHALL be ignored (no queueing); other opcodes/addresses SHALL be no-ops.
REQ-027 Digits not written keep their value; hex outputs registered, glitch-free.

Reset
REQ-028 reset_n low SHALL immediately force: FSM IDLE, ready=1, hex all 1111111, in_data=0, in_valid=0, lcd_data=0, lcd_line=0, lcd_we=0, synchronisers 0, debounce state not-pressed, counters 0.
REQ-029 Reset mid-conversion SHALL abandon it with no digit update; first request after release accepted normally.

Configuration
REQ-030 Macro IO_UNIT_DEBOUNCE_EN defined: key pressed state toggles only after synchronised key held opposite for DEB_CYCLES consecutive cycles; counter clears on any bounce.
REQ-031 Macro undefined: pressed state = inverted synchronised key, no counters synthesised.

Verification
REQ-032 Reset, OUT addr 3 data 5 -> next cycle hex digit3=0100100, all others 1111111.
REQ-033 OUT addr 31 data 1234 -> ready low 33 cycles, then digits3..0 = 1,2,3,4 codes, digits7..4 blank.
REQ-034 OUT addr 31 data 100000000 (NUM_HEX=8) -> all digits 1111110; data 0 -> digit0 0000001, rest blank.
REQ-035 DEBOUNCE_EN, DEB_CYCLES=4: key1 low 3 cycles then high -> IN addr 19 returns 0; low 10 cycles -> returns 1, in_valid one cycle.
REQ-036 reset_n pulsed 10 cycles into decimal conversion -> ready=1, hex all blank; OUT addr 0 data 7 then gives digit0=0001111.
REQ-037 OUT addr 9 data 32'h0000ABCD -> lcd_we one cycle, lcd_line=1, lcd_data=32'h0000ABCD; valid during busy ignored.

Source files
------------

// File: rtl/io_unit.sv
// io_unit: switch/key IN port plus seven-segment and LCD OUT port for an instruction stream.
// Latency: IN result, digit writes and LCD writes land 1 cycle after acceptance; decimal display (addr 31) holds ready low 33 cycles.
// Backpressure: ready=0 while a decimal conversion runs; valid seen with ready=0 is dropped, never queued.
// Optional feature macro: IO_UNIT_DEBOUNCE_EN (per-key stable-count debouncing).
module io_unit #(
  parameter int NUM_SW     = 18,
  parameter int NUM_KEY    = 4,
  parameter int NUM_HEX    = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [5:0]           opcode,
  input  logic [4:0]           address,
  input  logic [31:0]          data,
  input  logic                 valid,
  output logic                 ready,
  input  logic [NUM_SW-1:0]    sw,
  input  logic [NUM_KEY-1:0]   key,
  output logic [31:0]          in_data,
  output logic                 in_valid,
  output logic [7*NUM_HEX-1:0] hex,
  output logic [31:0]          lcd_data,
  output logic                 lcd_line,
  output logic                 lcd_we
);

  localparam logic [5:0] OP_IN     = 6'b011011;
  localparam logic [5:0] OP_OUT    = 6'b011100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_WRITE} state_t;

  state_t state, state_nxt;

  // Active-low segment pattern, bit0 = segment g; anything above 9 is blank.
  function automatic logic [6:0] seg_code(input logic [31:0] v);
    logic [6:0] s;
    case (v)
      32'd0:   s = 7'b0000001;
      32'd1:   s = 7'b1001111;
      32'd2:   s = 7'b0010010;
      32'd3:   s = 7'b0000110;
      32'd4:   s = 7'b1001100;
      32'd5:   s = 7'b0100100;
      32'd6:   s = 7'b0100000;
      32'd7:   s = 7'b0001111;
      32'd8:   s = 7'b0000000;
      32'd9:   s = 7'b0001100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [NUM_SW-1:0]  sw_s1, sw_s2;
  logic [NUM_KEY-1:0] key_s1, key_s2;
  logic [NUM_KEY-1:0] key_pressed;

  // Two-flop synchronisers for the asynchronous switch and key pins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

`ifdef IO_UNIT_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  logic [CW-1:0] deb_cnt [NUM_KEY];

  // Pressed state flips only after the synchronised key disagrees with it for DEB_CYCLES straight cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_pressed <= '0;
      for (int i = 0; i < NUM_KEY; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEY; i++) begin
        // key is active-low, so "disagrees" means the raw level equals the pressed flag.
        if (key_s2[i] == key_pressed[i]) begin
          if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
            key_pressed[i] <= ~key_pressed[i];
            deb_cnt[i]     <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign key_pressed = ~key_s2;
`endif

  logic accept, do_in, do_out;
  assign ready  = (state == S_IDLE);
  assign accept = valid && ready;
  assign do_in  = accept && (opcode == OP_IN);
  assign do_out = accept && (opcode == OP_OUT);

  logic in_bit;

  // IN address map: switches first, then keys, everything else reads 0.
  always_comb begin
    in_bit = 1'b0;
    for (int i = 0; i < NUM_SW; i++)
      if (address == 5'(i)) in_bit = sw_s2[i];
    for (int i = 0; i < NUM_KEY; i++)
      if (address == 5'(NUM_SW + i)) in_bit = key_pressed[i];
  end

  logic [31:0] bin_q;
  logic [39:0] bcd_q;
  logic [4:0]  cnt_q;
  logic [39:0] bcd_adj;
  logic [71:0] dd_next;

  // Double-dabble add-3 correction on every BCD digit before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < 10; d++)
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
  end

  assign dd_next = {bcd_adj, bin_q} << 1;

  logic                 overflow;
  logic                 shown;
  logic [7*NUM_HEX-1:0] dec_hex;

  // Decimal display image: dashes on overflow, otherwise digits with leading zeros blanked.
  always_comb begin
    overflow = 1'b0;
    for (int d = NUM_HEX; d < 10; d++)
      if (bcd_q[4*d +: 4] != 4'd0) overflow = 1'b1;
    shown   = 1'b0;
    dec_hex = '0;
    // Scan from the top digit down; once the first nonzero (or digit 0) is hit, all lower digits show.
    for (int d = NUM_HEX - 1; d >= 0; d--) begin
      if ((bcd_q[4*d +: 4] != 4'd0) || (d == 0)) shown = 1'b1;
      if (overflow)   dec_hex[7*d +: 7] = SEG_DASH;
      else if (shown) dec_hex[7*d +: 7] = seg_code({28'd0, bcd_q[4*d +: 4]});
      else            dec_hex[7*d +: 7] = SEG_BLANK;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: a decimal request runs 32 shift steps then one display write.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (do_out && (address == 5'd31)) state_nxt = S_CONVERT;
      S_CONVERT: if (cnt_q == 5'd31) state_nxt = S_WRITE;
      S_WRITE:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Request datapath: IN result, digit/LCD writes, and the conversion shift register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_data  <= '0;
      in_valid <= 1'b0;
      hex      <= {NUM_HEX{SEG_BLANK}};
      lcd_data <= '0;
      lcd_line <= 1'b0;
      lcd_we   <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
    end else begin
      in_valid <= do_in;
      lcd_we   <= 1'b0;
      if (do_in) in_data <= {31'd0, in_bit};
      if (do_out) begin
        for (int i = 0; i < NUM_HEX; i++)
          if (address == 5'(i)) hex[7*i +: 7] <= seg_code(data);
        if ((address == 5'd8) || (address == 5'd9)) begin
          lcd_data <= data;
          lcd_line <= address[0];
          lcd_we   <= 1'b1;
        end
        if (address == 5'd31) begin
          bin_q <= data;
          bcd_q <= '0;
          cnt_q <= '0;
        end
      end
      if (state == S_CONVERT) begin
        bcd_q <= dd_next[71:32];
        bin_q <= dd_next[31:0];
        cnt_q <= cnt_q + 5'd1;
      end
      if (state == S_WRITE) hex <= dec_hex;
    end
  end

endmodule

// File: tb/tb_io_unit.sv
`timescale 1ns/1ps
module tb_io_unit;
  localparam int NUM_SW = 18, NUM_KEY = 4, NUM_HEX = 8, DEB_CYCLES = 4;
  localparam int HW = 7 * NUM_HEX;
  localparam logic [5:0] OP_IN  = 6'b011011;
  localparam logic [5:0] OP_OUT = 6'b011100;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b1111110;
  localparam logic [6:0] SEG_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                          7'b0000000, 7'b0001100};

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic [5:0]         opcode = '0;
  logic [4:0]         address = '0;
  logic [31:0]        data = '0;
  logic               valid = 1'b0;
  logic               ready;
  logic [NUM_SW-1:0]  sw = '0;
  logic [NUM_KEY-1:0] key = '1;
  logic [31:0]        in_data;
  logic               in_valid;
  logic [HW-1:0]      hex;
  logic [31:0]        lcd_data;
  logic               lcd_line;
  logic               lcd_we;

  io_unit #(.NUM_SW(NUM_SW), .NUM_KEY(NUM_KEY), .NUM_HEX(NUM_HEX), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .address(address), .data(data),
    .valid(valid), .ready(ready), .sw(sw), .key(key), .in_data(in_data), .in_valid(in_valid),
    .hex(hex), .lcd_data(lcd_data), .lcd_line(lcd_line), .lcd_we(lcd_we)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit in_reset = 1'b1;

`ifdef IO_UNIT_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  typedef struct { int at; logic [31:0] d; } in_e_t;
  typedef struct { int at; logic [31:0] d; logic line; } lcd_e_t;
  typedef struct { int at; logic [HW-1:0] h; } hex_e_t;
  in_e_t  in_q[$];
  lcd_e_t lcd_q[$];
  hex_e_t hex_q[$];

  // Reference state: what the display and inputs should look like.
  logic [6:0]         m_dig [NUM_HEX];
  logic [HW-1:0]      m_hex_last;
  logic [NUM_SW-1:0]  m_sw = '0;
  logic [NUM_KEY-1:0] m_key = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input longint v);
    if (v >= 0 && v <= 9) return SEG_TAB[v];
    return BLANK;
  endfunction

  function automatic logic [HW-1:0] model_image();
    logic [HW-1:0] h;
    for (int i = 0; i < NUM_HEX; i++) h[7*i +: 7] = m_dig[i];
    return h;
  endfunction

  task automatic push_hex(input int at);
    logic [HW-1:0] h;
    h = model_image();
    if (h !== m_hex_last) hex_q.push_back('{at: at, h: h});
    m_hex_last = h;
  endtask

  // Decimal rendering from plain integer arithmetic.
  task automatic model_decimal(input logic [31:0] d);
    longint v, limit, t;
    int     digs [NUM_HEX];
    int     top;
    v = longint'(d);
    limit = 1;
    for (int i = 0; i < NUM_HEX; i++) limit = limit * 10;
    if (v >= limit) begin
      for (int i = 0; i < NUM_HEX; i++) m_dig[i] = DASH;
    end else begin
      t = v;
      top = 0;
      for (int i = 0; i < NUM_HEX; i++) begin
        digs[i] = int'(t % 10);
        t = t / 10;
        if (digs[i] != 0) top = i;
      end
      for (int i = 0; i < NUM_HEX; i++) m_dig[i] = (i <= top) ? seg_of(longint'(digs[i])) : BLANK;
    end
  endtask

  function automatic logic [31:0] in_expect(input logic [4:0] a);
    int ai;
    ai = int'(a);
    if (ai < NUM_SW) return {31'd0, m_sw[ai]};
    if (ai < NUM_SW + NUM_KEY) return {31'd0, ~m_key[ai - NUM_SW]};
    return 32'd0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive one request (called #1 after a rising edge) and record its expected effect.
  task automatic issue(input logic [5:0] op, input logic [4:0] a, input logic [31:0] d, input bit wait_busy = 1'b1);
    int n, busy;
    n = 0;
    while (!ready && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) check("ready_timeout", {63'd0, ready}, 64'd1);
    opcode = op; address = a; data = d; valid = 1'b1;
    tick(1);
    valid = 1'b0;
    if (op == OP_IN) begin
      in_q.push_back('{at: cyc, d: in_expect(a)});
    end else if (op == OP_OUT) begin
      if (int'(a) < NUM_HEX) begin
        m_dig[a] = seg_of(longint'(d));
        push_hex(cyc);
      end else if (a == 5'd8 || a == 5'd9) begin
        lcd_q.push_back('{at: cyc, d: d, line: a[0]});
      end else if (a == 5'd31) begin
        model_decimal(d);
        push_hex(cyc + 33);
        if (wait_busy) begin
          busy = 0;
          // Requests thrown at the busy unit must vanish.
          while (!ready && busy < 100) begin
            valid = 1'($urandom_range(0, 1));
            opcode = OP_OUT;
            address = 5'($urandom_range(0, 9));
            data = $urandom_range(0, 9);
            tick(1);
            busy++;
          end
          valid = 1'b0;
          check("busy_cycles", 64'(busy), 64'd33);
        end
      end
    end
  endtask

  task automatic set_inputs();
    m_sw = NUM_SW'($urandom);
    m_key = NUM_KEY'($urandom);
    sw = m_sw;
    key = m_key;
    tick(12);
  endtask

  task automatic do_reset(input int n);
    in_reset = 1'b1;
    reset_n = 1'b0;
    #1;
    check("rst_hex", 64'(hex), 64'({NUM_HEX{BLANK}}));
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_in_valid", 64'(in_valid), 64'd0);
    check("rst_in_data", 64'(in_data), 64'd0);
    check("rst_lcd_we", 64'(lcd_we), 64'd0);
    check("rst_lcd_data", 64'(lcd_data), 64'd0);
    check("rst_lcd_line", 64'(lcd_line), 64'd0);
    for (int i = 0; i < NUM_HEX; i++) m_dig[i] = BLANK;
    m_hex_last = model_image();
    in_q.delete();
    lcd_q.delete();
    hex_q.delete();
    tick(n);
    reset_n = 1'b1;
    tick(1);
    in_reset = 1'b0;
  endtask

  // Monitor: compare every presented output against the head of its queue.
  initial begin
    logic [HW-1:0] prev_hex;
    in_e_t  ie;
    lcd_e_t le;
    hex_e_t he;
    prev_hex = '1;
    forever begin
      @(negedge clock);
      if (in_reset) begin
        prev_hex = hex;
      end else begin
        if (in_valid) begin
          if (in_q.size() == 0) check("in_valid_unexpected", 64'd1, 64'd0);
          else begin
            ie = in_q.pop_front();
            check("in_data", 64'(in_data), 64'(ie.d));
            check("in_cycle", 64'(cyc), 64'(ie.at));
          end
        end
        if (lcd_we) begin
          if (lcd_q.size() == 0) check("lcd_we_unexpected", 64'd1, 64'd0);
          else begin
            le = lcd_q.pop_front();
            check("lcd_data", 64'(lcd_data), 64'(le.d));
            check("lcd_line", 64'(lcd_line), 64'(le.line));
            check("lcd_cycle", 64'(cyc), 64'(le.at));
          end
        end
        if (hex !== prev_hex) begin
          if (hex_q.size() == 0) check("hex_unexpected", 64'(hex), 64'(prev_hex));
          else begin
            he = hex_q.pop_front();
            check("hex_value", 64'(hex), 64'(he.h));
            check("hex_cycle", 64'(cyc), 64'(he.at));
          end
          prev_hex = hex;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    errors++;
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] d;
    int          r;
    @(posedge clock);
    #1;
    do_reset(4);
    set_inputs();

    // Single digit write, then decimal display cases.
    issue(OP_OUT, 5'd3, 32'd5);
    issue(OP_OUT, 5'd31, 32'd1234);
    issue(OP_OUT, 5'd31, 32'd100000000);
    issue(OP_OUT, 5'd31, 32'd0);
    issue(OP_OUT, 5'd31, 32'd99999999);
    issue(OP_OUT, 5'd31, 32'hFFFFFFFF);
    issue(OP_OUT, 5'd31, 32'd10);
    issue(OP_OUT, 5'd7, 32'd12);

    // LCD writes.
    issue(OP_OUT, 5'd9, 32'h0000ABCD);
    issue(OP_OUT, 5'd8, $urandom);

    // Key glitch and sustained press on key1 (address 19).
    key = '1; m_key = '1; sw = m_sw;
    tick(12);
    key[1] = 1'b0;
    tick(2);
    m_key[1] = DEB_EN ? 1'b1 : 1'b0;
    issue(OP_IN, 5'd19, 32'd0);
    key[1] = 1'b1;
    m_key[1] = 1'b1;
    tick(8);
    issue(OP_IN, 5'd19, 32'd0);
    key[1] = 1'b0;
    m_key[1] = 1'b0;
    tick(10);
    issue(OP_IN, 5'd19, 32'd0);
    check("ready_after_in", 64'(ready), 64'd1);
    issue(OP_IN, 5'd22, 32'd0);
    issue(OP_IN, 5'd31, 32'd0);

    // Randomised mix of reads, writes, decimal requests and no-ops.
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: set_inputs();
        1, 2, 3: issue(OP_IN, 5'($urandom_range(0, 31)), $urandom);
        4, 5, 6: issue(OP_OUT, 5'($urandom_range(0, 9)), $urandom_range(0, 15));
        7: begin
          case ($urandom_range(0, 2))
            0: d = $urandom;
            1: d = $urandom_range(0, 99999999);
            default: d = $urandom_range(0, 999);
          endcase
          issue(OP_OUT, 5'd31, d);
        end
        8: begin
          op = 6'($urandom);
          while (op == OP_IN || op == OP_OUT) op = 6'($urandom);
          issue(op, 5'($urandom_range(0, 31)), $urandom_range(0, 9));
        end
        default: issue(OP_OUT, 5'($urandom_range(10, 30)), $urandom_range(0, 9));
      endcase
    end

    // Reset in the middle of a decimal conversion, then a normal digit write.
    issue(OP_OUT, 5'd2, 32'd8);
    issue(OP_OUT, 5'd31, 32'd5678, 1'b0);
    tick(10);
    do_reset(3);
    issue(OP_OUT, 5'd0, 32'd7);
    tick(40);

    check("in_q_drained", 64'(in_q.size()), 64'd0);
    check("lcd_q_drained", 64'(lcd_q.size()), 64'd0);
    check("hex_q_drained", 64'(hex_q.size()), 64'd0);
    check("final_hex", 64'(hex), 64'({{(NUM_HEX-1){BLANK}}, 7'b0001111}));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
